// File: rtl/run_monitor.sv
// Run-control monitor for the MIPS core: watches the retire stream and halts on a NOP run,
// a misaligned PC, a breakpoint hit or a cycle budget, latching the cause and PC.
module run_monitor #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned CW          = 32,
  parameter int unsigned NOP_LIMIT   = 6,
  parameter int unsigned CYCLE_LIMIT = 10000000,
  parameter int unsigned NBP         = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  retire_i,
  input  logic [XLEN-1:0]       pc_i,
  input  logic [31:0]           ir_i,
  input  logic [NBP-1:0]        bp_en_i,
  input  logic [NBP*XLEN-1:0]   bp_addr_i,
  input  logic                  resume_i,
  output logic                  halt_o,
  output logic [2:0]            halt_cause_o,
  output logic [XLEN-1:0]       halt_pc_o,
  output logic [CW-1:0]         cycle_o,
  output logic [7:0]            nop_run_o
);

  localparam int unsigned NW = 8;
  localparam logic [2:0] C_NONE     = 3'd0;
  localparam logic [2:0] C_NOP      = 3'd1;
  localparam logic [2:0] C_MISALIGN = 3'd2;
  localparam logic [2:0] C_BP       = 3'd3;
  localparam logic [2:0] C_CYCLE    = 3'd4;

  typedef enum logic {S_RUN, S_HALT} state_e;

  state_e            state_q, state_d;
  logic              halt_q, halt_d;
  logic [2:0]        cause_q, cause_d;
  logic [XLEN-1:0]   halt_pc_q, halt_pc_d;
  logic [CW-1:0]     cycle_q, cycle_d;
  logic [NW-1:0]     nop_run_q, nop_run_d;
  logic [XLEN-1:0]   last_pc_q, last_pc_d;
  logic              skip_bp_q, skip_bp_d;

  logic              is_nop_c;
  logic              bp_hit_c;
  logic [NW:0]       nop_sum_c;
  logic [NW-1:0]     nop_sat_c;
  logic [CW:0]       cycle_sum_c;
  logic [CW-1:0]     cycle_sat_c;
  logic [2:0]        cause_c;

  // Halt-condition evaluation in priority order; only acted on while running.
  always_comb begin
    is_nop_c    = (ir_i == 32'd0);
    bp_hit_c    = 1'b0;
    nop_sum_c   = {1'b0, nop_run_q} + (NW+1)'(1);
    nop_sat_c   = (nop_run_q == {NW{1'b1}}) ? nop_run_q : nop_sum_c[NW-1:0];
    cycle_sum_c = {1'b0, cycle_q} + (CW+1)'(1);
    cycle_sat_c = (cycle_q == {CW{1'b1}}) ? cycle_q : cycle_sum_c[CW-1:0];
    cause_c     = C_NONE;
    for (int i = 0; i < int'(NBP); i++) begin
      if (bp_en_i[i] && (pc_i == bp_addr_i[i*XLEN +: XLEN])) begin
        bp_hit_c = 1'b1;
      end
    end
    if (retire_i && (pc_i[1:0] != 2'b00)) begin
      cause_c = C_MISALIGN;
    end else if (retire_i && bp_hit_c && !skip_bp_q) begin
      cause_c = C_BP;
    end else if (retire_i && is_nop_c && (NOP_LIMIT != 0) &&
                 (nop_sum_c >= (NW+1)'(NOP_LIMIT))) begin
      cause_c = C_NOP;
    end else if ((CYCLE_LIMIT != 0) && (cycle_sum_c >= (CW+1)'(CYCLE_LIMIT))) begin
      cause_c = C_CYCLE;
    end
  end

  // Next-state and register updates.
  always_comb begin
    state_d   = state_q;
    halt_d    = halt_q;
    cause_d   = cause_q;
    halt_pc_d = halt_pc_q;
    cycle_d   = cycle_q;
    nop_run_d = nop_run_q;
    last_pc_d = last_pc_q;
    skip_bp_d = skip_bp_q;
    if (state_q == S_RUN) begin
      cycle_d = cycle_sat_c;
      if (retire_i) begin
        nop_run_d = is_nop_c ? nop_sat_c : '0;
        last_pc_d = pc_i;
        skip_bp_d = 1'b0;
      end
      if (cause_c != C_NONE) begin
        state_d   = S_HALT;
        halt_d    = 1'b1;
        cause_d   = cause_c;
        halt_pc_d = (cause_c == C_CYCLE) ? last_pc_d : pc_i;
      end
    end else begin
      // Cycle-budget halts are sticky until reset.
      if (resume_i && (cause_q != C_CYCLE)) begin
        state_d   = S_RUN;
        halt_d    = 1'b0;
        cause_d   = C_NONE;
        nop_run_d = '0;
        skip_bp_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_RUN;
      halt_q    <= 1'b0;
      cause_q   <= C_NONE;
      halt_pc_q <= '0;
      cycle_q   <= '0;
      nop_run_q <= '0;
      last_pc_q <= '0;
      skip_bp_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      halt_q    <= halt_d;
      cause_q   <= cause_d;
      halt_pc_q <= halt_pc_d;
      cycle_q   <= cycle_d;
      nop_run_q <= nop_run_d;
      last_pc_q <= last_pc_d;
      skip_bp_q <= skip_bp_d;
    end
  end

  assign halt_o       = halt_q;
  assign halt_cause_o = cause_q;
  assign halt_pc_o    = halt_pc_q;
  assign cycle_o      = cycle_q;
  assign nop_run_o    = nop_run_q;

endmodule

// File: tb/tb_run_monitor.sv
// Bench for run_monitor: directed vector table, hand sequences and random stimulus
// compared against a behavioural model.
module tb_run_monitor;

  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 32;
  localparam int unsigned NOPL = 6;
  localparam int unsigned CYCL = 100;
  localparam int unsigned NBP  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, retire, resume;
  logic [31:0] pc, ir;
  logic [1:0]  bp_en;
  logic [63:0] bp_addr;
  logic        halt;
  logic [2:0]  cause;
  logic [31:0] hpc, cyc;
  logic [7:0]  nop;

  int checks   = 0;
  int failures = 0;

  run_monitor #(.XLEN(XLEN), .CW(CW), .NOP_LIMIT(NOPL), .CYCLE_LIMIT(CYCL), .NBP(NBP)) dut (
    .clk_i(clk), .rst_i(rst), .retire_i(retire), .pc_i(pc), .ir_i(ir),
    .bp_en_i(bp_en), .bp_addr_i(bp_addr), .resume_i(resume),
    .halt_o(halt), .halt_cause_o(cause), .halt_pc_o(hpc), .cycle_o(cyc), .nop_run_o(nop)
  );

  // Behavioural reference state
  bit      m_halt, m_skip;
  longint  m_cause, m_hpc, m_cyc, m_nop, m_last;

  task automatic model_reset();
    m_halt = 0; m_skip = 0; m_cause = 0; m_hpc = 0; m_cyc = 0; m_nop = 0; m_last = 0;
  endtask

  task automatic model_edge();
    longint new_cause;
    bit     hit;
    if (rst) begin
      model_reset();
    end else if (!m_halt) begin
      hit = 0;
      for (int i = 0; i < 2; i++)
        if (bp_en[i] && pc == bp_addr[i*32 +: 32]) hit = 1;
      new_cause = 0;
      if (retire && (pc % 4) != 0)                          new_cause = 2;
      else if (retire && hit && !m_skip)                     new_cause = 3;
      else if (retire && ir == 0 && m_nop + 1 >= NOPL)       new_cause = 1;
      else if (m_cyc + 1 >= CYCL)                            new_cause = 4;
      m_cyc = (m_cyc == 64'hFFFF_FFFF) ? m_cyc : m_cyc + 1;
      if (retire) begin
        m_nop  = (ir == 0) ? ((m_nop == 255) ? 255 : m_nop + 1) : 0;
        m_last = pc;
        m_skip = 0;
      end
      if (new_cause != 0) begin
        m_halt  = 1;
        m_cause = new_cause;
        m_hpc   = (new_cause == 4) ? m_last : longint'(pc);
      end
    end else if (resume && m_cause != 4) begin
      m_halt = 0; m_cause = 0; m_nop = 0; m_skip = 1;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply inputs at negedge, clock them in, step the model, settle to the next negedge.
  task automatic step(input bit r, input bit ret, input logic [31:0] p, input logic [31:0] i,
                      input bit res);
    rst = r; retire = ret; pc = p; ir = i; resume = res;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " halt"},  64'(halt),  64'(m_halt));
    chk({tag, " cause"}, 64'(cause), 64'(m_cause));
    chk({tag, " hpc"},   64'(hpc),   64'(m_hpc));
    chk({tag, " cycle"}, 64'(cyc),   64'(m_cyc));
    chk({tag, " nop"},   64'(nop),   64'(m_nop));
  endtask

  typedef struct {
    bit          rst, ret;
    logic [31:0] pc, ir;
    bit          e_halt;
    logic [2:0]  e_cause;
    logic [31:0] e_hpc, e_cyc;
    logic [7:0]  e_nop;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input bit ret, input logic [31:0] p, input logic [31:0] i,
                     input bit eh, input logic [2:0] ec, input logic [31:0] ep,
                     input logic [31:0] ey, input logic [7:0] en);
    vec_t v;
    v.rst = r; v.ret = ret; v.pc = p; v.ir = i;
    v.e_halt = eh; v.e_cause = ec; v.e_hpc = ep; v.e_cyc = ey; v.e_nop = en;
    tbl.push_back(v);
  endtask

  initial begin
    bit done;
    rst = 1; retire = 0; resume = 0; pc = 0; ir = 0; bp_en = 0; bp_addr = 0;
    model_reset();
    @(negedge clk);

    // NOP-run halt with frozen counters, then misaligned PC beating the NOP rule
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++)
      add(0, 1, 32'(4*k), 0, k == 5, (k == 5) ? 3'd1 : 3'd0, (k == 5) ? 32'h14 : 32'h0,
          32'(k+1), 8'(k+1));
    for (int k = 0; k < 10; k++) add(0, 0, 0, 0, 1, 1, 32'h14, 6, 6);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++)
      add(0, 1, 32'(32'h100 + 4*k), 0, 0, 0, 0, 32'(k+1), 8'(k+1));
    add(0, 1, 32'h102, 0, 1, 2, 32'h102, 6, 6);

    foreach (tbl[n]) begin
      step(tbl[n].rst, tbl[n].ret, tbl[n].pc, tbl[n].ir, 0);
      chk($sformatf("vec%0d halt", n),  64'(halt),  64'(tbl[n].e_halt));
      chk($sformatf("vec%0d cause", n), 64'(cause), 64'(tbl[n].e_cause));
      chk($sformatf("vec%0d hpc", n),   64'(hpc),   64'(tbl[n].e_hpc));
      chk($sformatf("vec%0d cycle", n), 64'(cyc),   64'(tbl[n].e_cyc));
      chk($sformatf("vec%0d nop", n),   64'(nop),   64'(tbl[n].e_nop));
    end

    // Non-NOP breaks the run
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 1, 32'(4*k), 0, 0);
    step(0, 1, 32'h14, 32'h2008_0001, 0);
    for (int k = 0; k < 5; k++) step(0, 1, 32'(32'h18 + 4*k), 0, 0);
    chk("t2 halt", 64'(halt), 0);
    chk("t2 nop", 64'(nop), 5);
    step(0, 1, 32'h2c, 0, 0);
    chk("t2 halt6", 64'(halt), 1);
    chk("t2 cause", 64'(cause), 1);

    // Breakpoint, resume steps past it, re-hit later
    step(1, 0, 0, 0, 0);
    bp_en = 2'b01; bp_addr = 64'h0000_0000_0000_0040;
    step(0, 1, 32'h3c, 32'h2008_0001, 0);
    chk("t4 pre", 64'(halt), 0);
    step(0, 1, 32'h40, 32'h2008_0001, 0);
    chk("t4 halt", 64'(halt), 1);
    chk("t4 cause", 64'(cause), 3);
    chk("t4 hpc", 64'(hpc), 32'h40);
    step(0, 1, 32'h41, 0, 0);
    chk("t4 held cause", 64'(cause), 3);
    chk("t4 held hpc", 64'(hpc), 32'h40);
    step(0, 0, 0, 0, 1);
    chk("t4 resumed", 64'(halt), 0);
    chk("t4 resumed cause", 64'(cause), 0);
    chk("t4 resumed hpc", 64'(hpc), 32'h40);
    step(0, 1, 32'h40, 32'h2008_0001, 0);
    chk("t4 skip", 64'(halt), 0);
    step(0, 1, 32'h44, 32'h2008_0001, 0);
    step(0, 1, 32'h40, 32'h2008_0001, 0);
    chk("t4 rehit", 64'(halt), 1);
    chk("t4 rehit cause", 64'(cause), 3);

    // Reset from HALT
    step(1, 0, 0, 0, 0);
    chk("t6 halt", 64'(halt), 0);
    chk("t6 cause", 64'(cause), 0);
    chk("t6 hpc", 64'(hpc), 0);
    chk("t6 cycle", 64'(cyc), 0);
    chk("t6 nop", 64'(nop), 0);
    step(0, 0, 0, 0, 0);
    chk("t6 count", 64'(cyc), 1);
    bp_en = 0;

    // Cycle budget, sticky against resume
    step(1, 0, 0, 0, 0);
    done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      step(0, 0, 0, 0, 0);
      done = halt;
    end
    chk("t5 reached", 64'(done), 1);
    chk("t5 cycle", 64'(cyc), 100);
    chk("t5 cause", 64'(cause), 4);
    chk("t5 hpc", 64'(hpc), 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1);
    chk("t5 sticky", 64'(halt), 1);
    chk("t5 frozen", 64'(cyc), 100);
    step(1, 0, 0, 0, 1);
    chk("t5 rst halt", 64'(halt), 0);
    chk("t5 rst cycle", 64'(cyc), 0);

    // Random episodes against the reference model
    bp_addr = {32'h48, 32'h40};
    for (int e = 0; e < 6; e++) begin
      bp_en = 2'($urandom_range(0, 3));
      step(1, 0, 0, 0, 0);
      chk_model("rnd rst");
      for (int k = 0; k < 130; k++) begin
        logic [31:0] rp;
        rp = 32'h3c + 32'(4 * $urandom_range(0, 4));
        if ($urandom_range(0, 19) == 0) rp = rp + 32'($urandom_range(1, 3));
        step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, rp,
             ($urandom_range(0, 9) < 6) ? 32'h0 : $urandom, $urandom_range(0, 9) == 0);
        chk_model($sformatf("rnd e%0d k%0d", e, k));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
